imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Receives a program image as a byte stream (e.g. from a UART receiver) and writes it word-by-word
//  into the instruction memory write port. Asserts start only after a complete image with a valid
//  checksum has been stored, releasing the fetch stage, which holds NOP while start is low.
//  Image format, all multi-byte fields little-endian:
//    LEN[31:0]     word count N
//    N x WORD[31:0]
//    CSUM[7:0]     sum mod 256 of all data bytes; LEN bytes are excluded
// PARAMETERS
//  IMEM_WORD  1024                instruction memory depth in 32-bit words
//  ADDR_W     $clog2(IMEM_WORD)   word address width
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high reset
//  rx_valid      in   1       byte available on rx_data
//  rx_data       in   8       incoming byte
//  rx_ready      out  1       loader can accept a byte; a byte transfers when rx_valid && rx_ready
//  imem_we       out  1       one-cycle write strobe to instruction memory
//  imem_waddr    out  ADDR_W  word address of the write
//  imem_wdata    out  32      word to write
//  start         out  1       image loaded and verified; held high until reset
//  load_error    out  1       sticky error flag: length overflow or checksum mismatch
//  words_loaded  out  ADDR_W+1  count of words written so far
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; the FSM is in S_LEN with byte index 0, running sum 0 and address 0.
//   - rx_ready is 0 during the reset cycle and 1 from the first cycle after it.
//  Reset is honoured in any state and aborts a load mid-image; words already written are not erased.
//  FSM states:
//   S_LEN:
//    - accept 4 bytes into len, filled LSB first.
//    - on the 4th byte: len > IMEM_WORD -> S_ERR; len == 0 -> S_CSUM; otherwise -> S_DATA.
//   S_DATA:
//    - accept bytes into a 32-bit shift register; byte k of a word goes to bits [8k+7:8k].
//    - every accepted byte is added mod 256 to the running sum.
//    - on the 4th byte of a word, in the next cycle: imem_we=1, imem_waddr=current address,
//      imem_wdata=assembled word. Address and words_loaded increment in that same cycle.
//    - after word N is accepted -> S_CSUM.
//   S_CSUM:
//    - accept 1 byte; equal to the running sum -> S_DONE, otherwise -> S_ERR.
//   S_DONE:
//    - rx_ready=0; start=1 registered (first high in the cycle after the CSUM byte is accepted).
//    - stays here until reset.
//   S_ERR:
//    - rx_ready=0; load_error=1 registered (first high in the cycle after the offending byte).
//    - start stays 0; stays here until reset.
//  Handshake rules:
//   - rx_ready depends only on state, never on rx_valid (no combinational loop).
//   - At most one byte per cycle; gaps in rx_valid of any length are allowed and leave state unchanged.
//   - rx_data is ignored when rx_valid=0.
//  Write timing:
//   - imem_we is never high for two consecutive cycles (bytes arrive at most one per cycle, 4 per word).
//   - imem_we is never asserted in S_LEN, S_CSUM, S_DONE or S_ERR, except the registered strobe
//     for word N, which may coincide with the first S_CSUM cycle.
//  Boundaries:
//   - len == IMEM_WORD is legal and fills the memory exactly; the address never wraps.
//   - start and load_error are never high together.
// TESTING
//  1. Bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | B6 ->
//     writes addr0=0x00000013 and addr1=0x00100093, start=1, load_error=0, words_loaded=2.
//  2. Same image with CSUM byte B7 -> both words written, load_error=1, start stays 0, rx_ready=0.
//  3. LEN = IMEM_WORD+1 (e.g. 01 04 00 00 with IMEM_WORD=1024) -> load_error=1, no imem_we pulse.
//  4. Case 1 with random 0-5 cycle gaps on rx_valid -> identical writes and start; imem_we is
//     never asserted for two consecutive cycles.
//  5. Assert reset after 6 data bytes of case 1, then resend case 1 in full ->
//     no write for the partial second word; after reload start=1 and words_loaded=2.
//  6. LEN 00 00 00 00 then CSUM 00 -> start=1 with no imem_we pulse; CSUM 01 instead -> load_error=1.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write signals of the boot loader.
// master: byte source / memory side (the testbench); slave: the loader itself.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              start;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, start, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_waddr, imem_wdata, start, load_error, words_loaded
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, checksummed byte-stream image into instruction memory and raises
// start once the whole image has been stored and its checksum verified.
module imem_boot_loader #(
  parameter int unsigned IMEM_WORD = 1024,
  parameter int unsigned ADDR_W    = $clog2(IMEM_WORD)
) (
  input logic               clk,
  input logic               reset,
  imem_boot_loader_if.slave bus
);

  typedef enum logic [2:0] {StLen, StData, StCsum, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       sh_q, sh_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [7:0]        sum_q, sum_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              err_q, err_d;

  logic        accept;
  logic [31:0] assembled;

  assign accept    = bus.rx_valid & ready_q;
  // The three previous bytes sit in sh_q; the current byte completes a LEN or data word.
  assign assembled = {bus.rx_data, sh_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StLen;
      idx_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      words_q <= '0;
      sum_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      words_q <= words_d;
      sum_q   <= sum_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    len_d   = len_q;
    words_d = words_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    start_d = start_q;
    err_d   = err_q;

    if (accept) begin
      idx_d = idx_q + 2'd1;
      sh_d  = {bus.rx_data, sh_q[23:8]};
      unique case (state_q)
        StLen: begin
          if (idx_q == 2'd3) begin
            if (assembled > IMEM_WORD) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else begin
              len_d   = assembled[ADDR_W:0];
              state_d = (assembled == 32'd0) ? StCsum : StData;
            end
          end
        end
        StData: begin
          sum_d = sum_q + bus.rx_data;
          if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            // words_q is the index of the word being completed, so it never wraps.
            waddr_d = words_q[ADDR_W-1:0];
            wdata_d = assembled;
            words_d = words_q + (ADDR_W + 1)'(1);
            if (words_d == len_q) state_d = StCsum;
          end
        end
        StCsum: begin
          if (bus.rx_data == sum_q) begin
            state_d = StDone;
            start_d = 1'b1;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Registered so ready stays low for the first cycle after reset.
    ready_d = (state_d == StLen) || (state_d == StData) || (state_d == StCsum);
  end

  always_comb begin
    bus.rx_ready     = ready_q;
    bus.imem_we      = we_q;
    bus.imem_waddr   = waddr_q;
    bus.imem_wdata   = wdata_q;
    bus.start        = start_q;
    bus.load_error   = err_q;
    bus.words_loaded = words_q;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: expected memory writes go to a scoreboard queue as
// images are sent, and a monitor pops and compares every imem_we pulse.
module tb_imem_boot_loader;

  localparam int unsigned IMEM_WORD = 1024;
  localparam int unsigned ADDR_W    = 10;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_boot_loader #(.IMEM_WORD(IMEM_WORD), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] img_words[$];
  bit          prev_we = 1'b0;

  // Write monitor: every strobe must match the scoreboard head and never follow another strobe.
  always @(negedge clk) begin
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (bus.imem_we) begin
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL we_consecutive: imem_we high on two consecutive cycles at %0t", $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%08h, required no write",
                   bus.imem_waddr, bus.imem_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                     bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
          end
        end
      end
      prev_we = bus.imem_we;
    end
  end

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    forever begin
      @(negedge clk);
      if (bus.rx_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL rx_ready_timeout: rx_ready=%0b for 50 cycles, required 1", bus.rx_ready);
        break;
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'hxx;
  endtask

  // Sends LEN, img_words and checksum (xored with csum_flip); stop_after >= 0 truncates the stream.
  task automatic send_image(input logic [31:0] len, input int gap_max, input int stop_after,
                            input logic [7:0] csum_flip);
    logic [7:0] bytes[$];
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    wr_t        e;
    for (int i = 0; i < 4; i++) bytes.push_back(len[8*i +: 8]);
    for (int w = 0; w < img_words.size(); w++) begin
      for (int i = 0; i < 4; i++) begin
        b = img_words[w][8*i +: 8];
        bytes.push_back(b);
        sum = sum + b;
      end
      if (stop_after < 0 || 4 + 4 * w + 4 <= stop_after) begin
        e.addr = w[ADDR_W-1:0];
        e.data = img_words[w];
        exp_q.push_back(e);
      end
    end
    bytes.push_back(sum ^ csum_flip);
    for (int k = 0; k < bytes.size(); k++) begin
      if (stop_after >= 0 && k >= stop_after) break;
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
      send_byte(bytes[k]);
    end
  endtask

  task automatic check_end(input string name, input logic exp_start, input logic exp_err,
                           input int exp_words);
    checks++;
    if (bus.start !== exp_start) begin
      errors++;
      $display("FAIL %s start: got %0b, required %0b", name, bus.start, exp_start);
    end
    checks++;
    if (bus.load_error !== exp_err) begin
      errors++;
      $display("FAIL %s load_error: got %0b, required %0b", name, bus.load_error, exp_err);
    end
    checks++;
    if (bus.words_loaded !== exp_words[ADDR_W:0]) begin
      errors++;
      $display("FAIL %s words_loaded: got %0d, required %0d", name, bus.words_loaded, exp_words);
    end
    checks++;
    if (bus.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s rx_ready: got %0b, required 0", name, bus.rx_ready);
    end
  endtask

  task automatic check_drained(input string name);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_writes: %0d pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic load_case1();
    img_words.delete();
    img_words.push_back(32'h0000_0013);
    img_words.push_back(32'h0010_0093);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.start !== 1'b0 ||
        bus.load_error !== 1'b0 || bus.words_loaded !== '0 || bus.imem_waddr !== '0 ||
        bus.imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b we=%0b st=%0b err=%0b wl=%0d wa=%0d wd=%08h, required 0",
               bus.rx_ready, bus.imem_we, bus.start, bus.load_error, bus.words_loaded,
               bus.imem_waddr, bus.imem_wdata);
    end
    idle(1);
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after: got %0b, required 1", bus.rx_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    load_case1();
    send_image(32'd2, 0, 12, 8'h00);
    checks++;
    if (bus.start !== 1'b0) begin
      errors++;
      $display("FAIL basic_start_early: got %0b, required 0", bus.start);
    end
    send_byte(8'hB6);
    check_end("basic", 1'b1, 1'b0, 2);
    check_drained("basic");
    check_end("basic_hold", 1'b1, 1'b0, 2);
  endtask

  task automatic test_bad_csum();
    do_reset();
    load_case1();
    send_image(32'd2, 0, -1, 8'h01);
    check_end("bad_csum", 1'b0, 1'b1, 2);
    check_drained("bad_csum");
  endtask

  task automatic test_len_overflow();
    do_reset();
    img_words.delete();
    send_image(IMEM_WORD + 1, 0, 4, 8'h00);
    check_end("len_overflow", 1'b0, 1'b1, 0);
    check_drained("len_overflow");
  endtask

  task automatic test_gaps();
    do_reset();
    load_case1();
    send_image(32'd2, 5, -1, 8'h00);
    check_end("gaps", 1'b1, 1'b0, 2);
    check_drained("gaps");
  endtask

  task automatic test_reset_abort();
    do_reset();
    load_case1();
    send_image(32'd2, 0, 10, 8'h00);
    check_drained("abort_partial");
    do_reset();
    checks++;
    if (bus.words_loaded !== '0 || bus.start !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: words_loaded=%0d start=%0b, required 0 0",
               bus.words_loaded, bus.start);
    end
    send_image(32'd2, 0, -1, 8'h00);
    check_end("abort_reload", 1'b1, 1'b0, 2);
    check_drained("abort_reload");
  endtask

  task automatic test_zero_len();
    do_reset();
    img_words.delete();
    send_image(32'd0, 0, -1, 8'h00);
    check_end("zero_len_ok", 1'b1, 1'b0, 0);
    check_drained("zero_len_ok");
    do_reset();
    send_image(32'd0, 0, -1, 8'h01);
    check_end("zero_len_bad", 1'b0, 1'b1, 0);
    check_drained("zero_len_bad");
  endtask

  task automatic test_full();
    do_reset();
    img_words.delete();
    for (int i = 0; i < IMEM_WORD; i++) img_words.push_back($urandom);
    send_image(IMEM_WORD, 0, -1, 8'h00);
    check_end("full", 1'b1, 1'b0, IMEM_WORD);
    check_drained("full");
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_overflow();
    test_gaps();
    test_reset_abort();
    test_zero_len();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
